div_tc_16_16_seq: RTL and testbench
===================================

Name: div_tc_16_16_seq

Overview:
- Sequential two's-complement 16/16 divider; the inverse operation of the combinational 16x16 signed multiplier in the FastMul area.
- Produces quotient and remainder with C truncation semantics: quotient rounds toward zero, remainder takes the sign of the dividend.
- Radix-2 restoring iteration on magnitudes, one quotient bit per clock, with a start/done handshake for use by a datapath controller.

Parameters:
- WIDTH, 16, operand/result width in bits. Only 16 is verified.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while busy=0.
- dividend  input  WIDTH  signed dividend; captured on the accepting edge.
- divisor  input  WIDTH  signed divisor; captured on the accepting edge.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- quotient  output  WIDTH  signed quotient.
- remainder  output  WIDTH  signed remainder.
- div_by_zero  output  1  result flag: divisor was 0.
- overflow  output  1  result flag: the case -2^(WIDTH-1) / -1.

Behaviour:
- Reset: async assert clears every output to 0 and forces IDLE. Reset may hit mid-operation; the operation is abandoned, done is never pulsed, and the next start is accepted normally after release.
- FSM states: IDLE, CALC, FIX.
- IDLE, start=1, divisor!=0 (edge E0):
  - latch |dividend| and |divisor| as WIDTH-bit unsigned magnitudes (|-32768| = 32768 fits);
  - latch both operand signs;
  - clear partial remainder (WIDTH+1 bits);
  - iteration counter = WIDTH; busy=1; go to CALC.
- CALC, edges E1..E16, one iteration per edge:
  - shift {rem, quo} left by 1, bringing in the dividend MSB;
  - trial = rem - divisor_mag; if trial >= 0, rem = trial and the quotient LSB = 1, else the quotient LSB = 0;
  - decrement the counter; after the WIDTH-th iteration go to FIX.
- FIX, edge E17:
  - quotient = negated magnitude if the operand signs differ;
  - remainder = negated magnitude if the dividend is negative;
  - update quotient/remainder, set overflow = (dividend==0x8000 && divisor==0xFFFF), div_by_zero=0;
  - done=1 for this one cycle, busy=0, go to IDLE.
  - Latency: start-accept edge to done = 17 edges.
- Overflow case: the natural result wraps. quotient=0x8000, remainder=0, overflow=1, with no special path.
- IDLE, start=1, divisor==0 (fast path) on edge E0:
  - quotient=all ones, remainder=dividend, div_by_zero=1, overflow=0;
  - done=1 in the following cycle; busy stays 0; state stays IDLE.
- start while busy=1: ignored. In-flight operands are unaffected, and the request is not queued.
- start held high continuously: a new operation is accepted on the edge where done is high, because state is IDLE then. Back-to-back throughput is one result per 18 cycles.
- quotient, remainder and flags hold their last values until the next result load or reset. They do not change during CALC.
- done and busy are never high in the same cycle.

Test Plan:
- Reset, then start with dividend=1000 (0x03E8), divisor=7 -> 17 edges later done=1 for one cycle, quotient=142 (0x008E), remainder=6, both flags 0; busy high for exactly 17 cycles.
- Sign matrix: -1000/7 gives q=0xFF72, r=0xFFFA; 1000/-7 gives q=0xFF72, r=0x0006; -1000/-7 gives q=0x008E, r=0xFFFA. Also cover 0/5 gives q=0, r=0, and 5/1000 gives q=0, r=5.
- Extremes: 0x8000/0xFFFF gives q=0x8000, r=0, overflow=1; 0x8000/0x0001 gives q=0x8000, overflow=0; 0x7FFF/0x8000 gives q=0, r=0x7FFF.
- Divide by zero: 5/0 gives done on the next cycle, q=0xFFFF, r=0x0005, div_by_zero=1, busy never high. A following 1000/7 clears div_by_zero.
- Handshake: pulse start again at cycle 5 of an operation with different operands -> the first result is unchanged and no second done occurs. With start held high, back-to-back results follow at an 18-cycle spacing.
- Reset mid-operation: deassert rst_n at cycle 8 of CALC -> busy=0, all outputs=0 immediately, no done pulse. A subsequent 100/-3 gives q=0xFFDF (-33), r=1.
- Random: 10 random signed pairs from a fixed seed, compared against the behavioural / and %, with divisor=0 handled per the fast-path rule.

Source files
------------

// File: rtl/div_tc_16_16_seq_if.sv
// Handshake and data bundle for the sequential signed divider.
// master: start/dividend/divisor out, results in; slave: the divider.
interface div_tc_16_16_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_tc_16_16_seq.sv
// Sequential two's-complement divider, radix-2 restoring, C truncation.
// Ports: clk, rst_n (async, active-low), bus (slave: start/operands in,
// busy/done/quotient/remainder/div_by_zero/overflow out).
module div_tc_16_16_seq #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    div_tc_16_16_seq_if.slave          bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    state_e           state_q, state_d;
    // Holds |dividend| at start and shifts into the quotient magnitude.
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             ovf_p_q, ovf_p_d;
    logic [WIDTH-1:0] q_out_q, q_out_d;
    logic [WIDTH-1:0] r_out_q, r_out_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             is_min, is_m1;

    always_comb begin
        a_mag   = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        b_mag   = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
        is_min  = bus.dividend == {1'b1, {(WIDTH-1){1'b0}}};
        is_m1   = bus.divisor == {WIDTH{1'b1}};
        // Partial remainder stays below the divisor, so its top bit is
        // always zero before the shift.
        shifted = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, dvs_q};
    end

    always_comb begin
        state_d = state_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        ovf_p_d = ovf_p_q;
        q_out_d = q_out_q;
        r_out_d = r_out_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        q_out_d = '1;
                        r_out_d = bus.dividend;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        quo_d   = a_mag;
                        dvs_d   = b_mag;
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        neg_a_d = bus.dividend[WIDTH-1];
                        neg_b_d = bus.divisor[WIDTH-1];
                        ovf_p_d = is_min && is_m1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!trial[WIDTH+1]) begin
                    rem_d = trial[WIDTH:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted;
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                q_out_d = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
                r_out_d = neg_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                ovf_d   = ovf_p_q;
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            quo_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            ovf_p_q <= 1'b0;
            q_out_q <= '0;
            r_out_q <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            ovf_p_q <= ovf_p_d;
            q_out_q <= q_out_d;
            r_out_q <= r_out_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Busy covers CALC and FIX; done is raised only on entry to IDLE,
    // so the two are never high together.
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = q_out_q;
    assign bus.remainder   = r_out_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_div_tc_16_16_seq.sv
// Directed bench for the sequential signed divider.
// Drives the interface master side and checks results, latency, handshake.
module tb_div_tc_16_16_seq;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

    div_tc_16_16_seq_if #(.WIDTH(16)) bus ();

    div_tc_16_16_seq #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for done, check latency and results.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input logic ez, input logic eo, input string tag);
        int lat;
        int nb;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        nb  = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) nb++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, (b == 16'h0) ? 1 : 18);
        chk({tag, "_busycyc"}, nb, (b == 16'h0) ? 0 : 17);
        chk({tag, "_busy_at_done"}, bus.busy, 1'b0);
        chk({tag, "_q"}, bus.quotient, eq);
        chk({tag, "_r"}, bus.remainder, er);
        chk({tag, "_dbz"}, bus.div_by_zero, ez);
        chk({tag, "_ovf"}, bus.overflow, eo);
        @(negedge clk);
        chk({tag, "_done_pulse"}, bus.done, 1'b0);
    endtask

    initial begin
        int cnt;
        int nd;
        logic [15:0] ra, rb, eq, er;
        int ai, bi;

        n_cmp = 0;
        n_mis = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_q", bus.quotient, 16'h0);
        chk("rst_r", bus.remainder, 16'h0);
        chk("rst_dbz", bus.div_by_zero, 1'b0);
        chk("rst_ovf", bus.overflow, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(16'd1000, 16'd7, 16'h008E, 16'h0006, 1'b0, 1'b0, "p_p");
        do_op(16'hFC18, 16'd7, 16'hFF72, 16'hFFFA, 1'b0, 1'b0, "n_p");
        do_op(16'd1000, 16'hFFF9, 16'hFF72, 16'h0006, 1'b0, 1'b0, "p_n");
        do_op(16'hFC18, 16'hFFF9, 16'h008E, 16'hFFFA, 1'b0, 1'b0, "n_n");
        do_op(16'd0, 16'd5, 16'h0000, 16'h0000, 1'b0, 1'b0, "zero_num");
        do_op(16'd5, 16'd1000, 16'h0000, 16'h0005, 1'b0, 1'b0, "small");
        do_op(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1, "ovf");
        do_op(16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, "min_1");
        do_op(16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 1'b0, 1'b0, "max_min");
        do_op(16'd5, 16'd0, 16'hFFFF, 16'h0005, 1'b1, 1'b0, "dbz");
        do_op(16'd1000, 16'd7, 16'h008E, 16'h0006, 1'b0, 1'b0, "dbz_clr");

        // Start pulsed mid-operation must be ignored.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd5;
        bus.divisor  = 16'd1;
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        while (!bus.done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("ign_done_seen", bus.done, 1'b1);
        chk("ign_q", bus.quotient, 16'h008E);
        chk("ign_r", bus.remainder, 16'h0006);
        nd = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) nd++;
            if (bus.busy) nd++;
        end
        chk("ign_no_second", nd, 0);

        // Start held high: back-to-back results 18 cycles apart.
        bus.start    = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd7;
        cnt = 0;
        @(negedge clk);
        while (!bus.done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("b2b_first", bus.done, 1'b1);
        chk("b2b_q1", bus.quotient, 16'h008E);
        cnt = 0;
        @(negedge clk);
        cnt++;
        while (!bus.done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        bus.start = 1'b0;
        chk("b2b_spacing", cnt, 18);
        chk("b2b_r2", bus.remainder, 16'h0006);
        @(negedge clk);
        chk("b2b_stop", bus.busy, 1'b0);

        // Reset in the middle of CALC.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_busy", bus.busy, 1'b0);
        chk("mid_done", bus.done, 1'b0);
        chk("mid_q", bus.quotient, 16'h0);
        chk("mid_r", bus.remainder, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("mid_no_done", nd, 0);
        do_op(16'd100, 16'hFFFD, 16'hFFDF, 16'h0001, 1'b0, 1'b0, "post_rst");

        // Seeded random pairs against integer / and %.
        void'($urandom(32'd2024));
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (rb == 16'h0) begin
                do_op(ra, rb, 16'hFFFF, ra, 1'b1, 1'b0, "rnd");
            end else begin
                ai = int'($signed(ra));
                bi = int'($signed(rb));
                eq = 16'(ai / bi);
                er = 16'(ai % bi);
                do_op(ra, rb, eq, er, 1'b0,
                      (ra == 16'h8000) && (rb == 16'hFFFF), "rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end
endmodule
